// File: rtl/soc_pkg.sv
// soc_pkg: FSM state encoding and test-pattern seed shared by the memory self-test.
package soc_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, READ_REQ, READ_WAIT, DONE} state_t;
  localparam logic [31:0] SEED = 32'hA5A5A5A5;
endpackage

// File: rtl/soc_mem.sv
// soc_mem: single-port synchronous memory with one-cycle read latency; array is not reset.
module soc_mem #(
  parameter int MEM_DEPTH = 64,
  parameter int DATA_WIDTH = 32,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  req_valid,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  valid_data
);
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  always_ff @(posedge clk) begin
    if (req_valid && we) mem[addr] <= wdata;
    if (req_valid && !we) rdata <= mem[addr];
    valid_data <= req_valid && !we;
  end
endmodule

// File: rtl/soc.sv
// soc: memory self-test master (write pattern, read back, compare) around soc_mem.
// Define SOC_ERR_INJECT_EN to flip bit 0 of the word read from address MEM_DEPTH/2.
module soc
  import soc_pkg::*;
#(
  parameter int MEM_DEPTH = 64,
  parameter int DATA_WIDTH = 32,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_req_valid,
  output logic                  dbg_we,
  output logic                  dbg_valid_data,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  done,
  output logic                  error
);
  function automatic logic [DATA_WIDTH-1:0] seed_w();
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < DATA_WIDTH; i++) r[i] = SEED[i % 32];
    return r;
  endfunction
  localparam logic [DATA_WIDTH-1:0] SEED_W = seed_w();
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    return SEED_W ^ DATA_WIDTH'(a);
  endfunction
  state_t state, state_d;
  logic [ADDR_WIDTH-1:0] addr, addr_d;
  logic error_d, req_valid, we, valid_data, mem_valid, last;
  logic [DATA_WIDTH-1:0] rdata, rd_data;
  assign last = addr == ADDR_WIDTH'(MEM_DEPTH - 1);
`ifdef SOC_ERR_INJECT_EN
  assign rd_data = rdata ^ DATA_WIDTH'(addr == ADDR_WIDTH'(MEM_DEPTH / 2));
`else
  assign rd_data = rdata;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      addr <= '0;
      error <= 1'b0;
    end else begin
      state <= state_d;
      addr <= addr_d;
      error <= error_d;
    end
  end
  always_comb begin
    state_d = state;
    addr_d = addr;
    case (state)
      IDLE: begin
        state_d = WRITE;
        addr_d = '0;
      end
      WRITE: begin
        state_d = last ? READ_REQ : WRITE;
        addr_d = last ? '0 : addr + 1'b1;
      end
      READ_REQ: state_d = READ_WAIT;
      READ_WAIT: begin
        state_d = last ? DONE : READ_REQ;
        addr_d = last ? addr : addr + 1'b1;
      end
      default: state_d = DONE;
    endcase
    error_d = error | (valid_data && rd_data != pattern(addr));
  end
  // Gating the memory's strobe by state kills a stale read immediately on reset.
  always_comb begin
    req_valid = state == WRITE || state == READ_REQ;
    we = state == WRITE;
    valid_data = mem_valid && state == READ_WAIT;
    done = state == DONE;
    dbg_data = we ? pattern(addr) : valid_data ? rd_data : '0;
  end
  assign dbg_addr = addr;
  assign dbg_req_valid = req_valid;
  assign dbg_we = we;
  assign dbg_valid_data = valid_data;
  soc_mem #(MEM_DEPTH, DATA_WIDTH) u_mem (
    .clk(clk),
    .req_valid(req_valid),
    .we(we),
    .addr(addr),
    .wdata(pattern(addr)),
    .rdata(rdata),
    .valid_data(mem_valid)
  );
endmodule

// File: tb/tb_soc.sv
// tb_soc: directed self-test of soc with hand-computed bus values at chosen edges after reset release.
module tb_soc;
  logic clk = 1'b1;
  logic reset = 1'b0;
  logic [5:0] dbg_addr;
  logic dbg_req_valid, dbg_we, dbg_valid_data, done, error;
  logic [31:0] dbg_data;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
`ifdef SOC_ERR_INJECT_EN
  localparam logic [31:0] RD32 = 32'hA5A5A584;
  localparam logic INJ = 1'b1;
`else
  localparam logic [31:0] RD32 = 32'hA5A5A585;
  localparam logic INJ = 1'b0;
`endif
  soc dut (
    .clk(clk),
    .reset(reset),
    .dbg_addr(dbg_addr),
    .dbg_req_valid(dbg_req_valid),
    .dbg_we(dbg_we),
    .dbg_valid_data(dbg_valid_data),
    .dbg_data(dbg_data),
    .done(done),
    .error(error)
  );
  always #10 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  task automatic run_to(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_addr"}, 64'(dbg_addr), 64'd0);
    check({tag, "_req"}, 64'(dbg_req_valid), 64'd0);
    check({tag, "_we"}, 64'(dbg_we), 64'd0);
    check({tag, "_vld"}, 64'(dbg_valid_data), 64'd0);
    check({tag, "_data"}, 64'(dbg_data), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(error), 64'd0);
  endtask
  initial begin
    #40;
    check_idle("rst");
    #10 reset = 1'b1;
    run_to(1);
    check("w0_addr", 64'(dbg_addr), 64'd0);
    check("w0_req", 64'(dbg_req_valid), 64'd1);
    check("w0_we", 64'(dbg_we), 64'd1);
    check("w0_data", 64'(dbg_data), 64'hA5A5A5A5);
    run_to(4);
    check("w3_addr", 64'(dbg_addr), 64'd3);
    check("w3_data", 64'(dbg_data), 64'hA5A5A5A6);
    run_to(64);
    check("w63_addr", 64'(dbg_addr), 64'd63);
    check("w63_we", 64'(dbg_we), 64'd1);
    check("w63_data", 64'(dbg_data), 64'hA5A5A59A);
    run_to(65);
    check("r0req_addr", 64'(dbg_addr), 64'd0);
    check("r0req_we", 64'(dbg_we), 64'd0);
    check("r0req_req", 64'(dbg_req_valid), 64'd1);
    check("r0req_vld", 64'(dbg_valid_data), 64'd0);
    check("r0req_data", 64'(dbg_data), 64'd0);
    run_to(66);
    check("r0_req", 64'(dbg_req_valid), 64'd0);
    check("r0_vld", 64'(dbg_valid_data), 64'd1);
    check("r0_data", 64'(dbg_data), 64'hA5A5A5A5);
    run_to(85);
    check("r10req_addr", 64'(dbg_addr), 64'd10);
    check("r10req_vld", 64'(dbg_valid_data), 64'd0);
    run_to(86);
    check("r10_vld", 64'(dbg_valid_data), 64'd1);
    check("r10_data", 64'(dbg_data), 64'hA5A5A5AF);
    check("r10_err", 64'(error), 64'd0);
    run_to(130);
    check("r32_addr", 64'(dbg_addr), 64'd32);
    check("r32_data", 64'(dbg_data), 64'(RD32));
    check("r32_err", 64'(error), 64'd0);
    run_to(131);
    check("r32_err_next", 64'(error), 64'(INJ));
    run_to(192);
    check("pre_done", 64'(done), 64'd0);
    run_to(193);
    check("done", 64'(done), 64'd1);
    check("done_err", 64'(error), 64'(INJ));
    check("done_req", 64'(dbg_req_valid), 64'd0);
    run_to(200);
    check("hold_done", 64'(done), 64'd1);
    check("hold_req", 64'(dbg_req_valid), 64'd0);
    check("hold_err", 64'(error), 64'(INJ));
    reset = 1'b0;
    cyc = 0;
    @(negedge clk);
    reset = 1'b1;
    run_to(100);
    check("mid_vld", 64'(dbg_valid_data), 64'd1);
    check("mid_addr", 64'(dbg_addr), 64'd17);
    reset = 1'b0;
    #1;
    check_idle("abort");
    @(negedge clk);
    @(negedge clk);
    check_idle("abort_hold");
    reset = 1'b1;
    cyc = 0;
    run_to(1);
    check("re_w0_we", 64'(dbg_we), 64'd1);
    check("re_w0_data", 64'(dbg_data), 64'hA5A5A5A5);
    run_to(192);
    check("re_pre_done", 64'(done), 64'd0);
    run_to(193);
    check("re_done", 64'(done), 64'd1);
    check("re_err", 64'(error), 64'(INJ));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
